// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the memory-game button front end: FSM state codes,
// default sizing and the one-hot check used to qualify a play.
package pkg_jogo;

  localparam int N_BOTOES_PADRAO        = 4;
  localparam int DEBOUNCE_CICLOS_PADRAO = 4;
  localparam int MAX_BOTOES             = 32;

  typedef enum logic [1:0] {
    ST_OCIOSO       = 2'b00,
    ST_FILTRA_PRESS = 2'b01,
    ST_PRESSIONADO  = 2'b10,
    ST_FILTRA_SOLTA = 2'b11
  } estado_t;

  // True when exactly one bit is set: nonzero and clearing the lowest set bit leaves zero.
  function automatic logic eh_one_hot(input logic [MAX_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - MAX_BOTOES'(1))) == '0);
  endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Button bus between the raw player buttons / control unit (master) and the
// conditioner (slave).
interface condicionador_botoes_if
  import pkg_jogo::*;
#(
  parameter int N_BOTOES = N_BOTOES_PADRAO
);

  logic [N_BOTOES-1:0] botoes;
  logic                habilita;
  logic                limpa;
  logic [N_BOTOES-1:0] jogada;
  logic                jogada_valida;
  logic                jogada_feita;
  logic [1:0]          db_estado;

  modport master (
    output botoes, habilita, limpa,
    input  jogada, jogada_valida, jogada_feita, db_estado
  );

  modport slave (
    input  botoes, habilita, limpa,
    output jogada, jogada_valida, jogada_feita, db_estado
  );

endinterface

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
// Two-flop synchroniser for an asynchronous bus; only the second stage may be
// consumed by downstream logic.
module sincronizador_2ff #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d_i,
  output logic [LARGURA-1:0] q_o
);

  logic [LARGURA-1:0] sync1_q;
  logic [LARGURA-1:0] sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Synchronises and debounces the player buttons, emitting one registered
// jogada_feita pulse per accepted press together with the latched pattern.
module condicionador_botoes
  import pkg_jogo::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input logic                    clock,
  input logic                    reset,
  condicionador_botoes_if.slave  botoes_if
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] sync2;
  estado_t             estado_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_BOTOES-1:0] amostra_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic                jogada_valida_q;
  logic                jogada_feita_q;

  sincronizador_2ff #(
    .LARGURA (N_BOTOES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (botoes_if.botoes),
    .q_o   (sync2)
  );

  // cnt never wraps: every state leaves or restarts it at CNT_MAX.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q        <= ST_OCIOSO;
      cnt_q           <= '0;
      amostra_q       <= '0;
      jogada_q        <= '0;
      jogada_valida_q <= 1'b0;
      jogada_feita_q  <= 1'b0;
    end else begin
      jogada_feita_q <= 1'b0;
      if (botoes_if.limpa) begin
        estado_q        <= ST_OCIOSO;
        cnt_q           <= '0;
        jogada_q        <= '0;
        jogada_valida_q <= 1'b0;
      end else begin
        case (estado_q)
          ST_OCIOSO: begin
            if (sync2 != '0) begin
              estado_q  <= ST_FILTRA_PRESS;
              amostra_q <= sync2;
              cnt_q     <= '0;
            end
          end
          ST_FILTRA_PRESS: begin
            if (sync2 == '0) begin
              estado_q <= ST_OCIOSO;
            end else if (sync2 != amostra_q) begin
              amostra_q <= sync2;
              cnt_q     <= '0;
            end else if (cnt_q == CNT_MAX) begin
              estado_q <= ST_PRESSIONADO;
              // Only habilita on the accepting edge decides whether this press counts.
              if (botoes_if.habilita) begin
                jogada_q        <= amostra_q;
                jogada_valida_q <= eh_one_hot(MAX_BOTOES'(amostra_q));
                jogada_feita_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_PRESSIONADO: begin
            if (sync2 == '0) begin
              estado_q <= ST_FILTRA_SOLTA;
              cnt_q    <= '0;
            end
          end
          ST_FILTRA_SOLTA: begin
            if (sync2 != '0) begin
              estado_q <= ST_PRESSIONADO;
            end else if (cnt_q == CNT_MAX) begin
              estado_q <= ST_OCIOSO;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: estado_q <= ST_OCIOSO;
        endcase
      end
    end
  end

  assign botoes_if.jogada        = jogada_q;
  assign botoes_if.jogada_valida = jogada_valida_q;
  assign botoes_if.jogada_feita  = jogada_feita_q;
  assign botoes_if.db_estado     = estado_q;

endmodule
